// File: rtl/rob_commit_ctrl_pkg.sv
// Shared types for the ROB commit scheduler: FSM states, per-slot descriptor,
// one-hot slot kinds and the special-retire priority order.
package rob_commit_ctrl_pkg;

  localparam int unsigned COMMIT_PC_W = 32;

  typedef enum logic [1:0] {
    S_RUN,
    S_UNCACHED,
    S_IDLE,
    S_FLUSH
  } commit_state_e;

  typedef struct packed {
    logic                   valid;
    logic                   exc;
    logic                   mispred;
    logic                   flush_inst;
    logic                   w_mem;
    logic                   uncached;
    logic                   idle;
    logic [COMMIT_PC_W-1:0] pc;
    logic [COMMIT_PC_W-1:0] target;
  } commit_slot_t;

  // One-hot slot kind; all-zero means the slot is not valid.
  localparam int unsigned KIND_N    = 6;
  localparam int unsigned SPECIAL_N = 5;
  localparam logic [2:0]  KI_PLAIN   = 3'd0;
  localparam logic [2:0]  KI_EXC     = 3'd1;
  localparam logic [2:0]  KI_UC      = 3'd2;
  localparam logic [2:0]  KI_IDLE    = 3'd3;
  localparam logic [2:0]  KI_MISPRED = 3'd4;
  localparam logic [2:0]  KI_FLUSH   = 3'd5;

  typedef logic [KIND_N-1:0] slot_kind_t;

  localparam slot_kind_t KIND_PLAIN = 6'b00_0001;

  // Highest priority first.
  localparam logic [2:0] EXC_PRIO [SPECIAL_N] = '{KI_EXC, KI_UC, KI_IDLE, KI_MISPRED, KI_FLUSH};

  function automatic logic [31:0] sat_add32(input logic [31:0] acc, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, acc} + {31'd0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/rob_commit_ctrl_classify.sv
// Combinational classifier for one ROB head slot: one-hot kind, store flag
// and the redirect address a mispredict/refetch on this slot would need.
module commit_slot_classify
  import rob_commit_ctrl_pkg::*;
(
  input  commit_slot_t           slot,
  output slot_kind_t             kind,
  output logic                   is_store,
  output logic [COMMIT_PC_W-1:0] redirect_pc
);

  logic [KIND_N-1:0] special;
  logic              found;

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    special             = '0;
    special[KI_EXC]     = slot.exc;
    special[KI_UC]      = slot.uncached;
    special[KI_IDLE]    = slot.idle;
    special[KI_MISPRED] = slot.mispred;
    special[KI_FLUSH]   = slot.flush_inst;
    kind                = '0;
    found               = 1'b0;
    if (slot.valid) begin
      if (special == '0) begin
        kind[KI_PLAIN] = 1'b1;
      end else begin
        for (int i = 0; i < SPECIAL_N; i++) begin
          if (!found && special[EXC_PRIO[i]]) begin
            kind[EXC_PRIO[i]] = 1'b1;
            found             = 1'b1;
          end
        end
      end
    end
  end

  assign is_store    = slot.valid & slot.w_mem;
  // Refetch resumes at the next sequential PC, wrapping at the top of the space.
  assign redirect_pc = slot.mispred ? slot.target : slot.pc + COMMIT_PC_W'(4);

endmodule

// File: rtl/rob_commit_ctrl.sv
// Commit scheduler for the 2-wide ROB head: retire count, serialised special
// retirements and the registered flush/redirect. Optional counters: ROB_COMMIT_PERF_EN.
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
#(
  parameter int unsigned PC_W       = COMMIT_PC_W,
  parameter int unsigned UC_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           commit_valid_i,
  input  logic [1:0]           exc_i,
  input  logic [1:0]           mispred_i,
  input  logic [1:0]           flush_inst_i,
  input  logic [1:0]           w_mem_i,
  input  logic [1:0]           uncached_i,
  input  logic [1:0]           idle_i,
  input  logic [1:0][PC_W-1:0] pc_i,
  input  logic [1:0][PC_W-1:0] target_i,
  input  logic [PC_W-1:0]      eentry_i,
  input  logic                 sb_ready_i,
  input  logic                 uc_done_i,
  input  logic                 int_pending_i,
  output logic [1:0]           commit_req_o,
  output logic                 uc_start_o,
  output logic                 exc_commit_o,
  output logic                 flush_o,
  output logic                 redirect_o,
  output logic [PC_W-1:0]      redirect_pc_o
`ifdef ROB_COMMIT_PERF_EN
  ,
  output logic [31:0]          perf_commit_o,
  output logic [31:0]          perf_flush_o,
  output logic [31:0]          perf_stall_o
`endif
);

  localparam int unsigned UC_CNT_W = (UC_TIMEOUT < 2) ? 1 : $clog2(UC_TIMEOUT + 1);

  commit_state_e        state;
  commit_state_e        nxt_state;
  commit_slot_t         slot0, slot1;
  slot_kind_t           kind0, kind1;
  logic                 store0, store1;
  logic [PC_W-1:0]      redir0, redir1;
  logic [PC_W-1:0]      idle_pc;
  logic [PC_W-1:0]      flush_pc;
  logic [UC_CNT_W-1:0]  uc_cnt;
  logic                 uc_timeout;
  logic                 do_flush;
  logic                 uc_go;
  logic                 idle_go;
  logic                 slot1_plain;
  logic                 unused_slot1;

  assign slot0 = '{valid: commit_valid_i[0], exc: exc_i[0], mispred: mispred_i[0],
                   flush_inst: flush_inst_i[0], w_mem: w_mem_i[0], uncached: uncached_i[0],
                   idle: idle_i[0], pc: pc_i[0], target: target_i[0]};
  assign slot1 = '{valid: commit_valid_i[1], exc: exc_i[1], mispred: mispred_i[1],
                   flush_inst: flush_inst_i[1], w_mem: w_mem_i[1], uncached: uncached_i[1],
                   idle: idle_i[1], pc: pc_i[1], target: target_i[1]};

  commit_slot_classify u_cls0 (
    .slot        (slot0),
    .kind        (kind0),
    .is_store    (store0),
    .redirect_pc (redir0)
  );

  commit_slot_classify u_cls1 (
    .slot        (slot1),
    .kind        (kind1),
    .is_store    (store1),
    .redirect_pc (redir1)
  );

  // Slot1 never redirects; its redirect candidate is intentionally dropped.
  assign unused_slot1 = ^redir1;
  assign slot1_plain  = (kind1 == KIND_PLAIN);
  assign uc_timeout   = (UC_TIMEOUT != 0) && (uc_cnt == UC_CNT_W'(UC_TIMEOUT));

  always_comb begin
    commit_req_o = 2'b00;
    exc_commit_o = 1'b0;
    nxt_state    = state;
    do_flush     = 1'b0;
    flush_pc     = '0;
    uc_go        = 1'b0;
    idle_go      = 1'b0;
    unique case (state)
      S_RUN: begin
        if (kind0[KI_EXC]) begin
          commit_req_o[0] = 1'b1;
          exc_commit_o    = 1'b1;
          do_flush        = 1'b1;
          flush_pc        = eentry_i;
        end else if (kind0[KI_UC]) begin
          uc_go     = 1'b1;
          nxt_state = S_UNCACHED;
        end else if (kind0[KI_IDLE]) begin
          commit_req_o[0] = 1'b1;
          idle_go         = 1'b1;
          nxt_state       = S_IDLE;
        end else if (kind0[KI_MISPRED] || kind0[KI_FLUSH]) begin
          commit_req_o[0] = 1'b1;
          do_flush        = 1'b1;
          flush_pc        = redir0;
        end else if (kind0[KI_PLAIN]) begin
          commit_req_o[0] = !(store0 && !sb_ready_i);
          // One store-buffer write per cycle; a slot1 store also needs the buffer ready.
          commit_req_o[1] = commit_req_o[0] && slot1_plain && !(store0 && store1)
                            && !(store1 && !sb_ready_i);
        end
      end
      S_UNCACHED: begin
        if (commit_valid_i[0] && uc_done_i) begin
          commit_req_o[0] = 1'b1;
          nxt_state       = S_RUN;
        end else if (commit_valid_i[0] && uc_timeout) begin
          commit_req_o[0] = 1'b1;
          exc_commit_o    = 1'b1;
          do_flush        = 1'b1;
          flush_pc        = eentry_i;
        end
      end
      S_IDLE: begin
        if (int_pending_i) begin
          do_flush = 1'b1;
          flush_pc = idle_pc + PC_W'(4);
        end
      end
      S_FLUSH: nxt_state = S_RUN;
      default: nxt_state = S_RUN;
    endcase
    if (do_flush) nxt_state = S_FLUSH;
    if (!rst_n) begin
      commit_req_o = 2'b00;
      exc_commit_o = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_RUN;
      flush_o       <= 1'b0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
      uc_start_o    <= 1'b0;
      uc_cnt        <= '0;
      idle_pc       <= '0;
    end else begin
      state      <= nxt_state;
      flush_o    <= do_flush;
      redirect_o <= do_flush;
      uc_start_o <= uc_go;
      if (do_flush) redirect_pc_o <= flush_pc;
      if (idle_go) idle_pc <= pc_i[0];
      if (uc_go) begin
        uc_cnt <= '0;
      end else if (state == S_UNCACHED && !uc_timeout && UC_TIMEOUT != 0) begin
        uc_cnt <= uc_cnt + UC_CNT_W'(1);
      end
    end
  end

`ifdef ROB_COMMIT_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_commit_o <= '0;
      perf_flush_o  <= '0;
      perf_stall_o  <= '0;
    end else begin
      perf_commit_o <= sat_add32(perf_commit_o,
                                 {1'b0, commit_req_o[0]} + {1'b0, commit_req_o[1]});
      perf_flush_o  <= sat_add32(perf_flush_o, {1'b0, flush_o});
      perf_stall_o  <= sat_add32(perf_stall_o, {1'b0, commit_valid_i[0] && !commit_req_o[0]});
    end
  end
`endif

endmodule
